// File: rtl/rfg_order_pkg.sv
// Shared types and header field positions for the register-file order engine.
package rfg_order_pkg;

    typedef enum logic [2:0] {
        ST_HEADER,
        ST_ADDR,
        ST_LEN,
        ST_WDATA,
        ST_WISSUE,
        ST_RISSUE,
        ST_RWAIT,
        ST_RSEND
    } state_e;

    localparam int HDR_READ_BIT = 7;
    localparam int HDR_INC_BIT  = 6;

endpackage

// File: rtl/rfg_order_engine.sv
// Decodes byte-stream read/write orders from a receive FIFO into register-file
// strobes and streams read results back out through a transmit FIFO.
module rfg_order_engine
    import rfg_order_pkg::*;
#(
    parameter int ADDR_BYTES = 1,
    parameter int LEN_BYTES  = 2,
    parameter int DATA_BYTES = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              ri_data,
    input  logic                    ri_empty,
    output logic                    ri_read,
    output logic                    wi_wr,
    output logic [7:0]              wi_data,
    input  logic                    wi_full,
    output logic [8*ADDR_BYTES-1:0] rfg_addr,
    output logic                    rfg_write,
    output logic [8*DATA_BYTES-1:0] rfg_write_data,
    output logic                    rfg_read,
    input  logic                    rfg_read_valid,
    input  logic [8*DATA_BYTES-1:0] rfg_read_data,
    output logic                    busy,
    output logic                    rd_timeout
);

    localparam int ADDR_W = 8 * ADDR_BYTES;
    localparam int LEN_W  = 8 * LEN_BYTES;
    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int BCNT_W = 3;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                is_rd_q, is_rd_d;
    logic                inc_q, inc_d;
    logic                rfg_write_q, rfg_write_d;
    logic                rfg_read_q, rfg_read_d;
    logic                busy_q, busy_d;
    logic                rd_timeout_q, rd_timeout_d;
    logic                pop, push, word_done;

    assign pop  = (state_q inside {ST_HEADER, ST_ADDR, ST_LEN, ST_WDATA}) && !ri_empty;
    assign push = (state_q == ST_RSEND) && !wi_full;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        word_d       = word_q;
        bcnt_d       = bcnt_q;
        tmo_d        = tmo_q;
        is_rd_d      = is_rd_q;
        inc_d        = inc_q;
        rd_timeout_d = 1'b0;
        word_done    = 1'b0;

        case (state_q)
            ST_HEADER: if (pop) begin
                is_rd_d = ri_data[HDR_READ_BIT];
                inc_d   = ri_data[HDR_INC_BIT];
                bcnt_d  = '0;
                state_d = ST_ADDR;
            end
            ST_ADDR: if (pop) begin
                addr_d = (addr_q << 8) | ADDR_W'(ri_data);
                if (bcnt_q == BCNT_W'(ADDR_BYTES - 1)) begin
                    bcnt_d  = '0;
                    state_d = ST_LEN;
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
            ST_LEN: if (pop) begin
                len_d = (len_q << 8) | LEN_W'(ri_data);
                if (bcnt_q == BCNT_W'(LEN_BYTES - 1)) begin
                    bcnt_d = '0;
                    if (len_d == '0)  state_d = ST_HEADER;
                    else if (is_rd_q) state_d = ST_RISSUE;
                    else              state_d = ST_WDATA;
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
            ST_WDATA: if (pop) begin
                word_d = (word_q << 8) | DATA_W'(ri_data);
                if (bcnt_q == BCNT_W'(DATA_BYTES - 1)) begin
                    bcnt_d  = '0;
                    state_d = ST_WISSUE;
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
            ST_WISSUE: word_done = 1'b1;
            ST_RISSUE: begin
                // a completion arriving alongside the request is taken immediately
                tmo_d  = '0;
                bcnt_d = '0;
                if (rfg_read_valid) begin
                    word_d  = rfg_read_data;
                    state_d = ST_RSEND;
                end else begin
                    state_d = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (rfg_read_valid) begin
                    word_d  = rfg_read_data;
                    state_d = ST_RSEND;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    word_d       = '0;
                    rd_timeout_d = 1'b1;
                    state_d      = ST_RSEND;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RSEND: if (push) begin
                word_d = word_q << 8;
                if (bcnt_q == BCNT_W'(DATA_BYTES - 1)) word_done = 1'b1;
                else                                   bcnt_d    = bcnt_q + BCNT_W'(1);
            end
            default: state_d = ST_HEADER;
        endcase

        if (word_done) begin
            len_d  = len_q - LEN_W'(1);
            bcnt_d = '0;
            if (inc_q) addr_d = addr_q + ADDR_W'(1);
            if (len_q == LEN_W'(1)) state_d = ST_HEADER;
            else if (is_rd_q)       state_d = ST_RISSUE;
            else                    state_d = ST_WDATA;
        end

        rfg_write_d = (state_d == ST_WISSUE);
        rfg_read_d  = (state_d == ST_RISSUE);
        busy_d      = (state_d != ST_HEADER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HEADER;
            addr_q       <= '0;
            len_q        <= '0;
            word_q       <= '0;
            bcnt_q       <= '0;
            tmo_q        <= '0;
            is_rd_q      <= 1'b0;
            inc_q        <= 1'b0;
            rfg_write_q  <= 1'b0;
            rfg_read_q   <= 1'b0;
            busy_q       <= 1'b0;
            rd_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            word_q       <= word_d;
            bcnt_q       <= bcnt_d;
            tmo_q        <= tmo_d;
            is_rd_q      <= is_rd_d;
            inc_q        <= inc_d;
            rfg_write_q  <= rfg_write_d;
            rfg_read_q   <= rfg_read_d;
            busy_q       <= busy_d;
            rd_timeout_q <= rd_timeout_d;
        end
    end

    // Outputs are forced low while rst is held so an abandoned order emits nothing.
    assign ri_read        = pop & ~rst;
    assign wi_wr          = push & ~rst;
    assign wi_data        = rst ? 8'h00 : word_q[DATA_W-1 -: 8];
    assign rfg_addr       = rst ? '0 : addr_q;
    assign rfg_write      = rfg_write_q & ~rst;
    assign rfg_write_data = rst ? '0 : word_q;
    assign rfg_read       = rfg_read_q & ~rst;
    assign busy           = busy_q & ~rst;
    assign rd_timeout     = rd_timeout_q & ~rst;

endmodule

// File: tb/tb_rfg_order_engine.sv
// Directed bench for rfg_order_engine: write, read, backpressure, timeout,
// address wrap, zero-length and mid-order reset.
module tb_rfg_order_engine;

    localparam int AB = 1, LB = 2, DB = 2, TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ri_data;
    logic        ri_empty;
    logic        ri_read;
    logic        wi_wr;
    logic [7:0]  wi_data;
    logic        wi_full;
    logic [7:0]  rfg_addr;
    logic        rfg_write;
    logic [15:0] rfg_write_data;
    logic        rfg_read;
    logic        rfg_read_valid = 1'b0;
    logic [15:0] rfg_read_data  = 16'h0;
    logic        busy;
    logic        rd_timeout;

    always #5 clk = ~clk;

    rfg_order_engine #(.ADDR_BYTES(AB), .LEN_BYTES(LB), .DATA_BYTES(DB), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ri_data(ri_data), .ri_empty(ri_empty), .ri_read(ri_read),
        .wi_wr(wi_wr), .wi_data(wi_data), .wi_full(wi_full),
        .rfg_addr(rfg_addr), .rfg_write(rfg_write), .rfg_write_data(rfg_write_data),
        .rfg_read(rfg_read), .rfg_read_valid(rfg_read_valid), .rfg_read_data(rfg_read_data),
        .busy(busy), .rd_timeout(rd_timeout)
    );

    // receive FIFO model
    logic [7:0] rx_mem [0:127];
    int rx_wr = 0, rx_rd = 0;
    assign ri_empty = (rx_rd == rx_wr);
    assign ri_data  = rx_mem[rx_rd[6:0]];
    always @(posedge clk) if (ri_read) rx_rd <= rx_rd + 1;

    // activity logs
    int cyc = 0, wr_n = 0, wi_n = 0, rd_n = 0, to_n = 0;
    logic [7:0]  wr_addr [0:63];
    logic [15:0] wr_data [0:63];
    int          wr_cyc  [0:63];
    logic [7:0]  wi_b    [0:127];
    logic [7:0]  rd_addr [0:63];
    int          rd_cyc  [0:63];
    int          to_cyc  [0:63];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rfg_write) begin
            wr_addr[wr_n[5:0]] <= rfg_addr;
            wr_data[wr_n[5:0]] <= rfg_write_data;
            wr_cyc[wr_n[5:0]]  <= cyc;
            wr_n <= wr_n + 1;
        end
        if (wi_wr) begin
            wi_b[wi_n[6:0]] <= wi_data;
            wi_n <= wi_n + 1;
        end
        if (rfg_read) begin
            rd_addr[rd_n[5:0]] <= rfg_addr;
            rd_cyc[rd_n[5:0]]  <= cyc;
            rd_n <= rd_n + 1;
        end
        if (rd_timeout) begin
            to_cyc[to_n[5:0]] <= cyc;
            to_n <= to_n + 1;
        end
    end

    // register-file read responder: completion three cycles after the request
    bit          rsp_en = 1'b1;
    logic        rsp_pend = 1'b0;
    int          rsp_cnt = 0, rsp_n = 0;
    logic [15:0] rsp_tab [0:7];

    always @(posedge clk) begin
        rfg_read_valid <= 1'b0;
        if (rfg_read && rsp_en) begin
            rsp_pend <= 1'b1;
            rsp_cnt  <= 1;
        end else if (rsp_pend) begin
            if (rsp_cnt == 2) begin
                rfg_read_valid <= 1'b1;
                rfg_read_data  <= rsp_tab[rsp_n[2:0]];
                rsp_n    <= rsp_n + 1;
                rsp_pend <= 1'b0;
            end else begin
                rsp_cnt <= rsp_cnt + 1;
            end
        end
    end

    int checks = 0, passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[rx_wr[6:0]] = b;
        rx_wr = rx_wr + 1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || rx_rd != rx_wr) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 300), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_strobes"}, {26'd0, ri_read, wi_wr, rfg_write, rfg_read, rd_timeout, busy}, 32'd0);
        chk({tag, "_addr"}, 32'(rfg_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(rfg_write_data), 32'd0);
        chk({tag, "_wi_data"}, 32'(wi_data), 32'd0);
    endtask

    initial begin
        int bw, bi, br, bt, n;
        rsp_tab[0] = 16'hBEEF; rsp_tab[1] = 16'hCAFE;
        rsp_tab[2] = 16'hBEEF; rsp_tab[3] = 16'hCAFE;
        rsp_tab[4] = 16'h1357; rsp_tab[5] = 16'h0;
        rsp_tab[6] = 16'h0;    rsp_tab[7] = 16'h0;
        rst = 1'b1;
        wi_full = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // two-word write with auto-increment, back to back
        bw = wr_n;
        push(8'h40); push(8'h10); push(8'h00); push(8'h02);
        push(8'hAB); push(8'hCD); push(8'h12); push(8'h34);
        wait_idle("w1_idle");
        chk("w1_count", 32'(wr_n - bw), 32'd2);
        chk("w1_addr0", 32'(wr_addr[bw]), 32'h10);
        chk("w1_data0", 32'(wr_data[bw]), 32'hABCD);
        chk("w1_addr1", 32'(wr_addr[bw+1]), 32'h11);
        chk("w1_data1", 32'(wr_data[bw+1]), 32'h1234);
        chk("w1_spacing", 32'(wr_cyc[bw+1] - wr_cyc[bw]), 32'd3);
        chk("w1_busy", 32'(busy), 32'd0);

        // two-word read, no increment
        bi = wi_n; br = rd_n;
        push(8'h80); push(8'h05); push(8'h00); push(8'h02);
        wait_idle("r1_idle");
        chk("r1_reads", 32'(rd_n - br), 32'd2);
        chk("r1_addr0", 32'(rd_addr[br]), 32'h05);
        chk("r1_addr1", 32'(rd_addr[br+1]), 32'h05);
        chk("r1_bytes", 32'(wi_n - bi), 32'd4);
        chk("r1_data", {wi_b[bi], wi_b[bi+1], wi_b[bi+2], wi_b[bi+3]}, 32'hBEEFCAFE);

        // same read with transmit backpressure after the first byte
        bi = wi_n;
        push(8'h80); push(8'h05); push(8'h00); push(8'h02);
        n = 0;
        while (wi_n == bi && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_first", 32'(n < 100), 32'd1);
        wi_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_hold_wr", 32'(wi_wr), 32'd0);
        end
        chk("bp_hold_cnt", 32'(wi_n - bi), 32'd1);
        wi_full = 1'b0;
        wait_idle("bp_idle");
        chk("bp_bytes", 32'(wi_n - bi), 32'd4);
        chk("bp_data", {wi_b[bi], wi_b[bi+1], wi_b[bi+2], wi_b[bi+3]}, 32'hBEEFCAFE);

        // read with no completion
        rsp_en = 1'b0;
        bi = wi_n; br = rd_n; bt = to_n;
        push(8'h80); push(8'h07); push(8'h00); push(8'h01);
        wait_idle("to_idle");
        chk("to_pulses", 32'(to_n - bt), 32'd1);
        chk("to_delay", 32'(to_cyc[bt] - rd_cyc[br]), 32'd17);
        chk("to_addr", 32'(rd_addr[br]), 32'h07);
        chk("to_bytes", 32'(wi_n - bi), 32'd2);
        chk("to_data", {16'h0, wi_b[bi], wi_b[bi+1]}, 32'h0000);
        rsp_en = 1'b1;

        // address wrap, then zero-length order, then a read to prove the decoder recovered
        bw = wr_n;
        push(8'h40); push(8'hFF); push(8'h00); push(8'h02);
        push(8'h11); push(8'h11); push(8'h22); push(8'h22);
        wait_idle("wrap_idle");
        chk("wrap_count", 32'(wr_n - bw), 32'd2);
        chk("wrap_addr0", 32'(wr_addr[bw]), 32'hFF);
        chk("wrap_data0", 32'(wr_data[bw]), 32'h1111);
        chk("wrap_addr1", 32'(wr_addr[bw+1]), 32'h00);
        chk("wrap_data1", 32'(wr_data[bw+1]), 32'h2222);
        bw = wr_n; br = rd_n;
        push(8'h00); push(8'h20); push(8'h00); push(8'h00);
        wait_idle("zl_idle");
        chk("zl_no_write", 32'(wr_n - bw), 32'd0);
        chk("zl_no_read", 32'(rd_n - br), 32'd0);
        bi = wi_n;
        push(8'h80); push(8'h20); push(8'h00); push(8'h01);
        wait_idle("zl_next_idle");
        chk("zl_next_addr", 32'(rd_addr[br]), 32'h20);
        chk("zl_next_data", {16'h0, wi_b[bi], wi_b[bi+1]}, 32'h1357);

        // reset after both data bytes of the first word, before the strobe escapes
        bw = wr_n;
        push(8'h40); push(8'h10); push(8'h00); push(8'h02);
        push(8'hAB); push(8'hCD);
        n = 0;
        while (rx_rd != rx_wr && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach", 32'(n < 100), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_gate_write", 32'(rfg_write), 32'd0);
        @(negedge clk);
        chk_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_write", 32'(wr_n - bw), 32'd0);
        push(8'h40); push(8'h30); push(8'h00); push(8'h01);
        push(8'h5A); push(8'hA5);
        wait_idle("rst_next_idle");
        chk("rst_next_count", 32'(wr_n - bw), 32'd1);
        chk("rst_next_addr", 32'(wr_addr[bw]), 32'h30);
        chk("rst_next_data", 32'(wr_data[bw]), 32'h5AA5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
